mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Four-requester round-robin arbiter that sequences a shared 4:1 mux tree built from 2:1 mux cells and presents the selected word on a valid/ready output port. It decides which requester owns the mux and drives the binary select pair for the tree. It also registers the grant and tracks the rotating priority pointer. It sits between four independent producers and a single downstream consumer.

## Interface
Parameters:
- WIDTH, 1, data width of each requester and of the output.
- CNT_W, 8, width of the accepted-transfer counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request per requester; held high until its ack.
- in_data  input  4*WIDTH  requester i's word at bits [i*WIDTH +: WIDTH].
- out_ready  input  1  downstream accepts when high with out_valid.
- out_valid  output  1  a granted word is presented.
- out_data  output  WIDTH  in_data slice selected by sel; 0 when out_valid=0.
- grant  output  4  one-hot owner, registered; 0 in IDLE.
- sel  output  2  binary index of owner, registered; sel[0] picks within pairs (0/1, 2/3), sel[1] picks the pair.
- ack  output  4  combinational; ack[i] = out_valid & out_ready & grant[i].
- xfer_count  output  CNT_W  count of accepted transfers, wraps.

## Operation
- State: IDLE or BUSY.
- Registered state: grant, sel, and the priority pointer ptr[1:0].
- Arbitration scans from ptr upward modulo 4. The first set bit of the candidate vector wins.
- IDLE:
  - If req != 0, arbitrate over req: grant <= onehot(winner), sel <= winner, go BUSY.
  - Otherwise stay in IDLE.
- out_valid = (state == BUSY).
- Accept = out_valid & out_ready. On accept:
  - ack[sel] asserts for that one cycle.
  - xfer_count increments modulo 2^CNT_W.
  - ptr <= sel+1 modulo 4.
  - Candidates = req & ~grant, so the current owner is masked for one cycle.
  - If candidates != 0, arbitrate using the new ptr and stay in BUSY with the new grant. Otherwise go to IDLE and clear grant.
- BUSY and not accepted:
  - If req[sel] is still high, hold grant, sel and out_data source.
  - If req[sel] is low (withdrawal), go to IDLE. grant clears, ptr is unchanged, no ack, and the count is unchanged.
- Accept and withdrawal in the same cycle: accept wins and counts as a transfer.
- Changes to in_data of the owner while BUSY pass straight to out_data. Producers must hold data stable until ack.
- Reset values: state IDLE, grant 0, sel 0, ptr 0 (requester 0 has highest priority), out_valid 0, out_data 0, ack 0, xfer_count 0.
- Reset asserted mid-transfer abandons the transfer with no ack and no count. Outputs take reset values on the next edge.

## Timing
- Request-to-valid latency is 1 cycle: req rises in IDLE at edge t, and out_valid/grant/sel are high after edge t+1.
- out_data is combinational from the registered sel plus in_data, so there is no additional latency.
- Back-to-back: with other requests pending at accept, out_valid stays high across the grant change and throughput is 1 word/cycle.
- A single requester that keeps req high after ack is re-granted 1 cycle later. This leaves a bubble: out_valid goes low for 1 cycle, via IDLE.
- ack is valid in the same cycle as the handshake. Requesters may drop req on the following edge.
- Fairness: with all four requesting continuously, the grant order is 0,1,2,3,0,... Each requester waits at most 3 transfers.

## Test plan
- Reset, then req=4'b0000 for 5 cycles -> out_valid=0, grant=0, sel=0, xfer_count=0 throughout.
- Single request: req=4'b0100, out_ready=1 -> next cycle grant=4'b0100, sel=2, out_data=in_data[2], ack=4'b0100 on the same cycle, xfer_count=1, then IDLE.
- All four requesting, out_ready=1, each req dropped after its ack and re-raised one cycle later -> ack order 0,1,2,3,0,1; out_valid continuously high after the first grant; xfer_count=6.
- Backpressure: req=4'b0011, out_ready=0 for 4 cycles, then 1 -> grant=4'b0001 and sel=0 held stable with no ack during stall; after accept, grant=4'b0010 with no bubble.
- Withdrawal: requester 3 granted with out_ready=0, then req[3] dropped -> next cycle out_valid=0, grant=0, no ack, xfer_count unchanged; a pending req[1] is granted the cycle after.
- Reset mid-BUSY with out_ready=0 -> after the reset edge all outputs are at reset values; with req=4'b1001 after reset, requester 0 is granted first (ptr=0).

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// Four-requester round-robin arbiter that owns a shared 4:1 mux tree (two levels
// of 2:1 cells) and presents the owner's word on a valid/ready output port.
module mux_rr_arbiter #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [3:0]           req,
   input  logic [4*WIDTH-1:0]   in_data,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   output logic [3:0]           grant,
   output logic [1:0]           sel,
   output logic [3:0]           ack,
   output logic [CNT_W-1:0]     xfer_count
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state, state_n;
   logic [3:0]       grant_n;
   logic [1:0]       sel_n;
   logic [1:0]       ptr, ptr_n;
   logic [CNT_W-1:0] cnt_n;
   logic [2:0]       pick;
   logic             accept;
   logic [WIDTH-1:0] lo_pair, hi_pair;

   // Returns {found, index} of the first set bit of vec scanning upward from start.
   function automatic logic [2:0] rr_pick(input logic [3:0] vec, input logic [1:0] start);
      logic [2:0] r;
      logic [1:0] idx;
      r = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         idx = start + 2'(i);
         if (vec[idx]) r = {1'b1, idx};
      end
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= '0;
         sel        <= '0;
         ptr        <= '0;
         xfer_count <= '0;
      end else begin
         state      <= state_n;
         grant      <= grant_n;
         sel        <= sel_n;
         ptr        <= ptr_n;
         xfer_count <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      grant_n = grant;
      sel_n   = sel;
      ptr_n   = ptr;
      cnt_n   = xfer_count;
      pick    = 3'b000;
      unique case (state)
         IDLE: begin
            if (|req) begin
               pick    = rr_pick(req, ptr);
               state_n = BUSY;
               sel_n   = pick[1:0];
               grant_n = 4'b0001 << pick[1:0];
            end
         end
         BUSY: begin
            if (accept) begin
               cnt_n = xfer_count + CNT_W'(1);
               ptr_n = sel + 2'd1;
               // The outgoing owner is masked so a lone requester goes back through IDLE.
               pick  = rr_pick(req & ~grant, sel + 2'd1);
               if (pick[2]) begin
                  sel_n   = pick[1:0];
                  grant_n = 4'b0001 << pick[1:0];
               end else begin
                  state_n = IDLE;
                  grant_n = '0;
               end
            end else if (!req[sel]) begin
               state_n = IDLE;
               grant_n = '0;
            end
         end
         default: begin
            state_n = IDLE;
            grant_n = '0;
         end
      endcase
   end

   always_comb begin
      out_valid = (state == BUSY);
      accept    = out_valid & out_ready;
      ack       = {4{accept}} & grant;
      lo_pair   = sel[0] ? in_data[WIDTH +: WIDTH]   : in_data[0 +: WIDTH];
      hi_pair   = sel[0] ? in_data[3*WIDTH +: WIDTH] : in_data[2*WIDTH +: WIDTH];
      out_data  = out_valid ? (sel[1] ? hi_pair : lo_pair) : '0;
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed vector table, a reactive fairness sequence,
// and randomized traffic checked against a behavioural round-robin model.
module tb_mux_rr_arbiter;
   localparam int W = 8;
   localparam int CW = 4;

   logic          clk, rst, out_ready, out_valid;
   logic [3:0]    req, grant, ack;
   logic [1:0]    sel;
   logic [4*W-1:0] in_data;
   logic [W-1:0]  out_data;
   logic [CW-1:0] xfer_count;

   int errors = 0;
   int checks = 0;

   mux_rr_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .req(req), .in_data(in_data), .out_ready(out_ready),
      .out_valid(out_valid), .out_data(out_data), .grant(grant), .sel(sel),
      .ack(ack), .xfer_count(xfer_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic       rdy;
      logic       v;
      logic [3:0] g;
      logic [1:0] s;
      logic       schk;
      logic [3:0] a;
      logic [3:0] c;
      logic [7:0] d;
   } vec_t;
   vec_t vecs[$];

   // Behavioural model: owner index, priority pointer, transfer count.
   bit m_busy;
   int m_own, m_ptr, m_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int first_from(input logic [3:0] v, input int start);
      for (int k = 0; k < 4; k++) begin
         int j;
         j = (start + k) % 4;
         if (v[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_update(input logic r, input logic [3:0] q, input logic rdy);
      int w;
      if (r) begin
         m_busy = 0; m_own = 0; m_ptr = 0; m_cnt = 0;
      end else if (!m_busy) begin
         w = first_from(q, m_ptr);
         if (w >= 0) begin m_busy = 1; m_own = w; end
      end else if (rdy) begin
         m_cnt = (m_cnt + 1) % (1 << CW);
         m_ptr = (m_own + 1) % 4;
         w = first_from(q & ~(4'b0001 << m_own), m_ptr);
         if (w >= 0) m_own = w;
         else m_busy = 0;
      end else if (!q[m_own]) begin
         m_busy = 0;
      end
   endtask

   task automatic model_check(input string tag);
      logic [3:0] eg, ea;
      logic [7:0] ed;
      eg = m_busy ? (4'b0001 << m_own) : 4'b0000;
      ea = (m_busy && out_ready) ? eg : 4'b0000;
      ed = m_busy ? in_data[m_own*W +: W] : 8'h00;
      chk({tag, ".valid"}, 32'(out_valid), 32'(m_busy));
      chk({tag, ".grant"}, 32'(grant), 32'(eg));
      chk({tag, ".ack"}, 32'(ack), 32'(ea));
      chk({tag, ".data"}, 32'(out_data), 32'(ed));
      chk({tag, ".count"}, 32'(xfer_count), 32'(m_cnt));
      if (m_busy) chk({tag, ".sel"}, 32'(sel), 32'(m_own));
   endtask

   task automatic add(input logic r, input logic [3:0] q, input logic rdy, input logic v,
                      input logic [3:0] g, input logic [1:0] s, input logic schk,
                      input logic [3:0] a, input logic [3:0] c, input logic [7:0] d);
      vec_t e;
      e.rst = r; e.req = q; e.rdy = rdy; e.v = v; e.g = g; e.s = s; e.schk = schk;
      e.a = a; e.c = c; e.d = d;
      vecs.push_back(e);
   endtask

   initial begin
      int acks[$];
      int order[6];
      logic [3:0] req_h;
      logic seen_v, gap;

      rst = 1'b1; req = 4'b0000; out_ready = 1'b0; in_data = 32'h44332211;
      repeat (2) @(posedge clk);
      model_update(1'b1, 4'b0000, 1'b0);

      //   rst  req     rdy  v   grant   sel  schk ack     cnt  data
      for (int i = 0; i < 5; i++)
         add(0, 4'b0000, 0,  0,  4'b0000, 0,  1,  4'b0000, 0,  8'h00);
      add(0, 4'b0100, 1,  0,  4'b0000, 0,  0,  4'b0000, 0,  8'h00);
      add(0, 4'b0100, 1,  1,  4'b0100, 2,  1,  4'b0100, 0,  8'h33);
      add(0, 4'b0000, 1,  0,  4'b0000, 0,  0,  4'b0000, 1,  8'h00);
      add(1, 4'b0000, 0,  0,  4'b0000, 0,  0,  4'b0000, 1,  8'h00);
      add(0, 4'b1111, 1,  0,  4'b0000, 0,  1,  4'b0000, 0,  8'h00);
      add(0, 4'b1111, 1,  1,  4'b0001, 0,  1,  4'b0001, 0,  8'h11);
      add(0, 4'b1110, 1,  1,  4'b0010, 1,  1,  4'b0010, 1,  8'h22);
      add(0, 4'b1101, 1,  1,  4'b0100, 2,  1,  4'b0100, 2,  8'h33);
      add(0, 4'b1011, 1,  1,  4'b1000, 3,  1,  4'b1000, 3,  8'h44);
      add(0, 4'b0111, 1,  1,  4'b0001, 0,  1,  4'b0001, 4,  8'h11);
      add(0, 4'b1110, 1,  1,  4'b0010, 1,  1,  4'b0010, 5,  8'h22);
      add(0, 4'b0000, 0,  1,  4'b0100, 2,  1,  4'b0000, 6,  8'h33);
      add(0, 4'b0000, 0,  0,  4'b0000, 0,  0,  4'b0000, 6,  8'h00);
      add(0, 4'b0011, 0,  0,  4'b0000, 0,  0,  4'b0000, 6,  8'h00);
      for (int i = 0; i < 4; i++)
         add(0, 4'b0011, 0,  1,  4'b0001, 0,  1,  4'b0000, 6,  8'h11);
      add(0, 4'b0011, 1,  1,  4'b0001, 0,  1,  4'b0001, 6,  8'h11);
      add(0, 4'b0010, 0,  1,  4'b0010, 1,  1,  4'b0000, 7,  8'h22);
      add(0, 4'b0010, 1,  1,  4'b0010, 1,  1,  4'b0010, 7,  8'h22);
      add(0, 4'b0000, 0,  0,  4'b0000, 0,  0,  4'b0000, 8,  8'h00);
      add(0, 4'b1010, 0,  0,  4'b0000, 0,  0,  4'b0000, 8,  8'h00);
      add(0, 4'b1010, 0,  1,  4'b1000, 3,  1,  4'b0000, 8,  8'h44);
      add(0, 4'b0010, 0,  1,  4'b1000, 3,  1,  4'b0000, 8,  8'h44);
      add(0, 4'b0010, 0,  0,  4'b0000, 0,  0,  4'b0000, 8,  8'h00);
      add(0, 4'b0010, 0,  1,  4'b0010, 1,  1,  4'b0000, 8,  8'h22);
      add(1, 4'b0010, 0,  1,  4'b0010, 1,  1,  4'b0000, 8,  8'h22);
      add(0, 4'b1001, 0,  0,  4'b0000, 0,  1,  4'b0000, 0,  8'h00);
      add(0, 4'b1001, 0,  1,  4'b0001, 0,  1,  4'b0000, 0,  8'h11);

      foreach (vecs[i]) begin
         @(negedge clk);
         rst = vecs[i].rst; req = vecs[i].req; out_ready = vecs[i].rdy;
         #1;
         chk($sformatf("vec%0d.valid", i), 32'(out_valid), 32'(vecs[i].v));
         chk($sformatf("vec%0d.grant", i), 32'(grant), 32'(vecs[i].g));
         chk($sformatf("vec%0d.ack", i), 32'(ack), 32'(vecs[i].a));
         chk($sformatf("vec%0d.count", i), 32'(xfer_count), 32'(vecs[i].c));
         chk($sformatf("vec%0d.data", i), 32'(out_data), 32'(vecs[i].d));
         if (vecs[i].schk) chk($sformatf("vec%0d.sel", i), 32'(sel), 32'(vecs[i].s));
         model_update(rst, req, out_ready);
      end

      // Reactive fairness: each producer drops req after its ack and re-raises next cycle.
      @(negedge clk);
      rst = 1'b1; req = 4'b0000; out_ready = 1'b1;
      model_update(rst, req, out_ready);
      req_h = 4'b1111; seen_v = 1'b0; gap = 1'b0;
      for (int cyc = 0; cyc < 20 && acks.size() < 6; cyc++) begin
         @(negedge clk);
         rst = 1'b0; req = req_h; out_ready = 1'b1; in_data = $urandom;
         #1;
         if (seen_v && !out_valid) gap = 1'b1;
         if (out_valid) seen_v = 1'b1;
         for (int i = 0; i < 4; i++) if (ack[i]) acks.push_back(i);
         model_check("fair");
         model_update(rst, req, out_ready);
         req_h = 4'b1111 & ~ack;
      end
      order = '{0, 1, 2, 3, 0, 1};
      chk("fair.ack_total", 32'(acks.size()), 32'd6);
      for (int i = 0; i < 6; i++)
         if (i < acks.size()) chk($sformatf("fair.order%0d", i), 32'(acks[i]), 32'(order[i]));
      chk("fair.no_bubble", 32'(gap), 32'd0);
      @(negedge clk);
      req = req_h; out_ready = 1'b0;
      #1;
      chk("fair.count", 32'(xfer_count), 32'd6);
      model_update(rst, req, out_ready);

      // Randomized traffic, with occasional withdrawals, stalls and resets.
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 99) == 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_data = $urandom;
         for (int i = 0; i < 4; i++) begin
            if (ack[i])      req[i] = 1'($urandom_range(0, 1));
            else if (req[i]) req[i] = ($urandom_range(0, 19) != 0);
            else             req[i] = ($urandom_range(0, 3) == 0);
         end
         #1;
         model_check("rand");
         model_update(rst, req, out_ready);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
